// File: rtl/bcd_auto_counter_display.sv
// Multi-digit BCD up/down counter stepped by an internal tick divider,
// with synchronous load, wrap modulus and per-digit 7-segment drive.
module bcd_auto_counter_display #(
  parameter int DIV       = 50_000_000,
  parameter int DIGITS    = 2,
  parameter int MAX_COUNT = 59,
  parameter int BLANK_LZ  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [7*DIGITS-1:0]   seg_o,
  output logic                  tick_o,
  output logic                  wrap_o,
  output logic                  load_err
);

  localparam int BW = 4 * DIGITS;
  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    int            t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  localparam logic [BW-1:0] MAX_BCD  = to_bcd(MAX_COUNT);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] r_div;
  logic [BW-1:0] r_cnt;
  logic          r_tick;
  logic          r_wrap;
  logic          r_err;

  logic [BW-1:0] w_inc;
  logic [BW-1:0] w_dec;
  logic          w_ld_ok;
  logic [7*DIGITS-1:0] w_seg;

  // Per-digit ripple carry (inc) and borrow (dec)
  always_comb begin
    logic       c;
    logic       b;
    logic [3:0] d;
    w_inc   = '0;
    w_dec   = '0;
    w_ld_ok = (load_val <= MAX_BCD);
    c = 1'b1;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = r_cnt[4*i+:4];
      if (c && d == 4'd9) begin
        w_inc[4*i+:4] = 4'd0;
      end else begin
        w_inc[4*i+:4] = d + {3'd0, c};
        c = 1'b0;
      end
      if (b && d == 4'd0) begin
        w_dec[4*i+:4] = 4'd9;
      end else begin
        w_dec[4*i+:4] = d - {3'd0, b};
        b = 1'b0;
      end
      if (load_val[4*i+:4] > 4'd9) w_ld_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (load && w_ld_ok) begin
        r_cnt  <= load_val;
        r_div  <= '0;
        r_tick <= 1'b0;
      end else begin
        if (load) r_err <= 1'b1;
        if (en) begin
          r_div  <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
          r_tick <= (r_div == DIV_LAST);
        end else begin
          r_tick <= 1'b0;
        end
        if (r_tick) begin
          if (up) begin
            if (r_cnt == MAX_BCD) begin
              r_cnt  <= '0;
              r_wrap <= 1'b1;
            end else begin
              r_cnt <= w_inc;
            end
          end else begin
            if (r_cnt == '0) begin
              r_cnt  <= MAX_BCD;
              r_wrap <= 1'b1;
            end else begin
              r_cnt <= w_dec;
            end
          end
        end
      end
    end
  end

  // Leading-zero blanking scans from the most significant digit down
  always_comb begin
    logic       hi_nz;
    logic [3:0] d;
    w_seg = '1;
    hi_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d     = r_cnt[4*i+:4];
      hi_nz = hi_nz | (d != 4'd0);
      if (BLANK_LZ != 0 && i > 0 && !hi_nz)
        w_seg[7*i+:7] = 7'h7F;
      else
        w_seg[7*i+:7] = dec7(d);
    end
  end

  assign bcd_o    = r_cnt;
  assign seg_o    = w_seg;
  assign tick_o   = r_tick;
  assign wrap_o   = r_wrap;
  assign load_err = r_err;

endmodule
